// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the five-stage RISC-V core.
//
// Owns the program counter, drives the instruction ROM and holds the IF/ID
// pipeline register that feeds the decode stage. A taken redirect from ID
// squashes the wrong-path word fetched in the same cycle (no delay slot).
//
// Ports:
//   clk                     in   1  clock, all state on rising edge
//   rst                     in   1  asynchronous active-high reset
//   stall                   in   6  ctrl stall vector: [0] PC, [1] IF, [2] ID
//   branch_flag_i           in   1  taken redirect resolved in ID this cycle
//   branch_target_address_i in  32  redirect target from ID
//   rom_data_i              in  32  instruction word at rom_addr_o
//   rom_addr_o              out 32  current PC
//   rom_ce_o                out  1  ROM chip enable
//   id_pc_o                 out 32  PC of instruction held in IF/ID
//   id_inst_o               out 32  instruction held in IF/ID
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  logic        ce_reg;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_inst_reg, id_inst_next;

  // Upper stall bits belong to later stages; target low bits are discarded
  // because fetch addresses are always word aligned.
  logic unused_bits;
  assign unused_bits = ^{stall[5:3], branch_target_address_i[1:0]};

  // PC: a stall beats a concurrent redirect; the branch is still in ID
  // (also stalled) and will re-assert once the stall clears.
  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (!ce_reg)
      pc_next = RESET_PC;
    else if (stall[0])
      pc_next = pc_reg;
    else if (branch_flag_i)
      pc_next = {branch_target_address_i[31:2], 2'b00};
  end

  // IF/ID: insert a bubble when IF stalls but ID moves on, hold when both
  // stall, and flush the wrong-path fetch on redirect or before fetch starts.
  always_comb begin
    id_pc_next   = pc_reg;
    id_inst_next = rom_data_i;
    if (stall[1]) begin
      if (stall[2]) begin
        id_pc_next   = id_pc_reg;
        id_inst_next = id_inst_reg;
      end else begin
        id_pc_next   = 32'd0;
        id_inst_next = BUBBLE_INST;
      end
    end else if (!ce_reg || branch_flag_i) begin
      id_pc_next   = 32'd0;
      id_inst_next = BUBBLE_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_reg      <= 1'b0;
      pc_reg      <= RESET_PC;
      id_pc_reg   <= 32'd0;
      id_inst_reg <= BUBBLE_INST;
    end else begin
      ce_reg      <= 1'b1;
      pc_reg      <= pc_next;
      id_pc_reg   <= id_pc_next;
      id_inst_reg <= id_inst_next;
    end
  end

  assign rom_addr_o = pc_reg;
  assign rom_ce_o   = ce_reg;
  assign id_pc_o    = id_pc_reg;
  assign id_inst_o  = id_inst_reg;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] rom_data_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom_data_i              (rom_data_i),
    .rom_addr_o              (rom_addr_o),
    .rom_ce_o                (rom_ce_o),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o)
  );

  always #5 clk = ~clk;

  // ROM image: word i = 32'h0010_0093 + i at byte address 4*i.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h0010_0093 + (addr >> 2);
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] addr,
                              input logic [31:0] ipc, input logic [31:0] inst);
    check_eq({tag, ".addr"}, rom_addr_o, addr);
    check_eq({tag, ".id_pc"}, id_pc_o, ipc);
    check_eq({tag, ".id_inst"}, id_inst_o, inst);
    $display("%-10s addr=%08h id_pc=%08h id_inst=%08h ce=%0b", tag, rom_addr_o, id_pc_o, id_inst_o, rom_ce_o);
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b0;
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'd0;
    step();
    step();
    check_eq("rst.ce", {31'd0, rom_ce_o}, 32'd0);
    expect_state("rst", 32'h0, 32'h0, BUBBLE);

    // Start-up sequence.
    rst = 1'b0;
    step();
    check_eq("e1.ce", {31'd0, rom_ce_o}, 32'd1);
    expect_state("e1", 32'h0, 32'h0, BUBBLE);
    step(); expect_state("e2", 32'h4, 32'h0, 32'h0010_0093);
    step(); expect_state("e3", 32'h8, 32'h4, 32'h0010_0094);
    step(); expect_state("e4", 32'hC, 32'h8, 32'h0010_0095);
    step(); expect_state("e5", 32'h10, 32'hC, 32'h0010_0096);

    // Taken jump to unaligned target 0x102 -> 0x100, one bubble.
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h0000_0102;
    step(); expect_state("jmp", 32'h100, 32'h0, BUBBLE);
    branch_flag_i = 1'b0;
    step(); expect_state("jmp+1", 32'h104, 32'h100, 32'h0010_00D3);

    // Reposition so PC=0x20 with ID holding 0x1C.
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h0000_001C;
    step(); expect_state("to1c", 32'h1C, 32'h0, BUBBLE);
    branch_flag_i = 1'b0;
    step(); expect_state("at20", 32'h20, 32'h1C, 32'h0010_009A);

    // Full stall of PC/IF/ID for 3 cycles.
    stall = 6'b000111;
    for (int i = 0; i < 3; i++) begin
      step(); expect_state("stall3", 32'h20, 32'h1C, 32'h0010_009A);
    end
    stall = 6'b0;
    step(); expect_state("resume", 32'h24, 32'h20, 32'h0010_009B);
    step(); expect_state("run28", 32'h28, 32'h24, 32'h0010_009C);

    // IF stalled, ID not: bubble into ID, PC holds.
    stall = 6'b000011;
    step(); expect_state("ifstall", 32'h28, 32'h0, BUBBLE);
    stall = 6'b0;
    step(); expect_state("ifrel", 32'h2C, 32'h28, 32'h0010_009D);

    // Stall overrides a concurrent redirect; honored once released.
    stall = 6'b000111;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h0000_0200;
    step(); expect_state("stbr", 32'h2C, 32'h28, 32'h0010_009D);
    stall = 6'b0;
    step(); expect_state("br200", 32'h200, 32'h0, BUBBLE);
    branch_flag_i = 1'b0;
    step(); expect_state("br200+1", 32'h204, 32'h200, 32'h0010_0113);

    // PC wrap at the top of the address space.
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'hFFFF_FFFE;
    step(); expect_state("tofffc", 32'hFFFF_FFFC, 32'h0, BUBBLE);
    branch_flag_i = 1'b0;
    step(); expect_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h4010_0092);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.ce", {31'd0, rom_ce_o}, 32'd0);
    expect_state("arst", 32'h0, 32'h0, BUBBLE);
    rst = 1'b0;
    step();
    check_eq("re1.ce", {31'd0, rom_ce_o}, 32'd1);
    expect_state("re1", 32'h0, 32'h0, BUBBLE);
    step(); expect_state("re2", 32'h4, 32'h0, 32'h0010_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
